// File: rtl/drt_pkg.sv
// drt_pkg -- shared constants for the Wishbone device ROM table.
//
// Holds the register map layout (header size, words per device entry,
// word offsets inside an entry, status bit position), the FSM state type
// and a helper that computes the first invalid word address for a given
// device count.
package drt_pkg;

  // Header occupies words 0..3; each device entry occupies four words.
  localparam int HDR_WORDS     = 4;
  localparam int WORDS_PER_DEV = 4;

  // Word index within a device entry (low two address bits).
  localparam logic [1:0] W_ID     = 2'd0;
  localparam logic [1:0] W_FLAGS  = 2'd1;
  localparam logic [1:0] W_OFFSET = 2'd2;
  localparam logic [1:0] W_SIZE   = 2'd3;

  // Header word addresses.
  localparam logic [31:0] ADR_VERSION_ID = 32'd0;
  localparam logic [31:0] ADR_COUNT      = 32'd1;
  localparam logic [31:0] ADR_STATUS     = 32'd2;

  // Bit inside the status word that reports a pending flag change.
  localparam int STATUS_PENDING_BIT = 0;

  // Bus handshake states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } drt_state_e;

  // One past the last valid word address of the table.
  function automatic logic [31:0] map_limit(input int num_devices);
    return 32'(HDR_WORDS + WORDS_PER_DEV * num_devices);
  endfunction

endpackage

// File: rtl/drt_entry_bank.sv
// drt_entry_bank -- storage and read mux for the per-device entries.
//
// Each device has four words: ID, flags, base offset and size. ID, offset
// and size are constants taken from the packed parameters (entry 0 in the
// LSBs); the flags words are registers loaded from DEV_FLAGS_INIT on reset
// and rewritable through wr_en.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   dev, word     selected device index and word within the entry
//   wr_en         write wr_data into the selected device's flags register
//   wr_data       value for a flags write
//   rd_data       selected entry word (0 when dev is out of range)
//   wr_changes    wr_data differs from the selected flags register
module drt_entry_bank
  import drt_pkg::*;
#(
  parameter int                         NUM_DEVICES    = 1,
  parameter logic [32*NUM_DEVICES-1:0]  DEV_IDS        = '0,
  parameter logic [32*NUM_DEVICES-1:0]  DEV_FLAGS_INIT = '0,
  parameter logic [32*NUM_DEVICES-1:0]  DEV_OFFSETS    = '0,
  parameter logic [32*NUM_DEVICES-1:0]  DEV_SIZES      = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  dev,
  input  logic [1:0]  word,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        wr_changes
);

  logic [31:0] flags [NUM_DEVICES];

  // Flags registers; the device index is compared per entry so an
  // out-of-range index simply writes nothing.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_DEVICES; i++) begin
      if (rst) begin
        flags[i] <= DEV_FLAGS_INIT[32*i +: 32];
      end else if (wr_en && (dev == 4'(i))) begin
        flags[i] <= wr_data;
      end
    end
  end

  // Read mux and change detection for the selected entry.
  always_comb begin
    rd_data    = '0;
    wr_changes = 1'b0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      if (dev == 4'(i)) begin
        case (word)
          W_ID:     rd_data = DEV_IDS[32*i +: 32];
          W_FLAGS:  rd_data = flags[i];
          W_OFFSET: rd_data = DEV_OFFSETS[32*i +: 32];
          default:  rd_data = DEV_SIZES[32*i +: 32];
        endcase
        wr_changes = (flags[i] != wr_data);
      end
    end
  end

endmodule

// File: rtl/wb_device_rom_table.sv
// wb_device_rom_table -- Wishbone slave exposing a device ROM table.
//
// Word map: 0 = {version, id}, 1 = device count, 2 = status (bit 0 set
// while a flags change is pending), 3 = 0, then four words per device
// (ID, flags, offset, size). Reads of valid words are acked; writes are
// acked only for flags words when FLAGS_WRITABLE is set; everything else
// gets err. Each request produces one response cycle WAIT_STATES+1 cycles
// after the sampling edge, then the slave waits for the strobe to drop.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i         Wishbone cycle, strobe, write enable
//   wbs_adr_i, wbs_dat_i         word address and write data
//   wbs_ack_o, wbs_err_o         single-cycle response
//   wbs_dat_o                    read data, zero outside the response cycle
//   wbs_int_o                    level interrupt: flags change pending
module wb_device_rom_table
  import drt_pkg::*;
#(
  parameter int                         NUM_DEVICES    = 1,
  parameter logic [15:0]                DRT_VERSION    = 16'h0001,
  parameter logic [15:0]                DRT_ID         = 16'hC594,
  parameter logic [32*NUM_DEVICES-1:0]  DEV_IDS        = '0,
  parameter logic [32*NUM_DEVICES-1:0]  DEV_FLAGS_INIT = '0,
  parameter logic [32*NUM_DEVICES-1:0]  DEV_OFFSETS    = '0,
  parameter logic [32*NUM_DEVICES-1:0]  DEV_SIZES      = '0,
  parameter int                         WAIT_STATES    = 0,
  parameter bit                         FLAGS_WRITABLE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_int_o
);

  localparam logic [31:0] MAP_LIMIT = map_limit(NUM_DEVICES);

  drt_state_e  state;
  logic [2:0]  wait_cnt;
  logic [31:0] lat_adr;
  logic [31:0] lat_dat;
  logic        lat_we;
  logic        pending;

  logic [31:0] req_adr;
  logic [31:0] req_dat;
  logic        req_we;
  logic        adr_valid;
  logic        in_header;
  logic [3:0]  dev_idx;
  logic        is_flag_wr;
  logic        is_ok;
  logic [31:0] hdr_word;
  logic [31:0] bank_rd;
  logic        bank_changes;
  logic [31:0] rd_word;
  logic        commit;
  logic        enter_resp;

  // In IDLE the request is decoded straight from the bus so a zero-wait
  // response can be formed at the sampling edge; afterwards the latched
  // copy is used.
  always_comb begin
    if (state == ST_IDLE) begin
      req_adr = wbs_adr_i;
      req_dat = wbs_dat_i;
      req_we  = wbs_we_i;
    end else begin
      req_adr = lat_adr;
      req_dat = lat_dat;
      req_we  = lat_we;
    end
  end

  // Address decode. For addresses 4..67 the entry index is (adr>>2)-1;
  // 4-bit wrap-around keeps device 15 (slot 16) correct.
  always_comb begin
    adr_valid  = (req_adr < MAP_LIMIT);
    in_header  = (req_adr < 32'(HDR_WORDS));
    dev_idx    = req_adr[5:2] - 4'd1;
    is_flag_wr = req_we && FLAGS_WRITABLE && adr_valid && !in_header &&
                 (req_adr[1:0] == W_FLAGS);
    is_ok      = adr_valid && (!req_we || is_flag_wr);
  end

  // Header words and final read data selection.
  always_comb begin
    hdr_word = '0;
    case (req_adr[1:0])
      2'd0:    hdr_word = {DRT_VERSION, DRT_ID};
      2'd1:    hdr_word = 32'(NUM_DEVICES);
      2'd2:    hdr_word[STATUS_PENDING_BIT] = pending;
      default: hdr_word = '0;
    endcase
    rd_word = in_header ? hdr_word : bank_rd;
  end

  // Side effects (flags write, status clear) land on the edge that ends
  // the response cycle; the response itself is registered on entry.
  assign commit     = (state == ST_RESP);
  assign enter_resp = ((state == ST_IDLE) && wbs_cyc_i && wbs_stb_i && (WAIT_STATES == 0)) ||
                      ((state == ST_WAIT) && wbs_cyc_i && (wait_cnt == 3'd1));

  drt_entry_bank #(
    .NUM_DEVICES   (NUM_DEVICES),
    .DEV_IDS       (DEV_IDS),
    .DEV_FLAGS_INIT(DEV_FLAGS_INIT),
    .DEV_OFFSETS   (DEV_OFFSETS),
    .DEV_SIZES     (DEV_SIZES)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .dev       (dev_idx),
    .word      (req_adr[1:0]),
    .wr_en     (commit && is_flag_wr),
    .wr_data   (req_dat),
    .rd_data   (bank_rd),
    .wr_changes(bank_changes)
  );

  // Handshake FSM with registered ack/err/data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      lat_adr   <= '0;
      lat_dat   <= '0;
      lat_we    <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
      if (enter_resp) begin
        wbs_ack_o <= is_ok;
        wbs_err_o <= !is_ok;
        wbs_dat_o <= (is_ok && !req_we) ? rd_word : '0;
      end
      case (state)
        ST_IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            lat_adr <= wbs_adr_i;
            lat_dat <= wbs_dat_i;
            lat_we  <= wbs_we_i;
            if (WAIT_STATES > 0) begin
              state    <= ST_WAIT;
              wait_cnt <= 3'(WAIT_STATES);
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (!wbs_cyc_i) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else if (wait_cnt == 3'd1) begin
            state    <= ST_RESP;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ST_RESP: begin
          state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!wbs_stb_i) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pending flag: set by a flags write that changes a value, cleared by an
  // acked read of the status word (whose data was captured before this).
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (commit && is_flag_wr && bank_changes) begin
      pending <= 1'b1;
    end else if (commit && is_ok && !req_we && (req_adr == ADR_STATUS)) begin
      pending <= 1'b0;
    end
  end

  assign wbs_int_o = pending;

endmodule

// File: tb/tb_wb_device_rom_table.sv
// tb_wb_device_rom_table -- self-checking bench for wb_device_rom_table.
//
// Two devices, two wait states, writable flags. A table-level model keeps
// the expected flags words and pending bit; each access is compared for
// response kind, data, latency (edge at which the master sees the
// response, counted from the request-sampling edge) and response count.
module tb_wb_device_rom_table;

  localparam int N  = 2;
  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_i;
  logic        ack, err, int_o;
  logic [31:0] dat_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] m_ids   [N] = '{32'h1, 32'h2};
  logic [31:0] m_offs  [N] = '{32'h1000, 32'h2000};
  logic [31:0] m_sizes [N] = '{32'h100, 32'h200};
  logic [31:0] m_init  [N] = '{32'h11, 32'h22};
  logic [31:0] m_flags [N];
  logic        m_pending;

  wb_device_rom_table #(
    .NUM_DEVICES   (N),
    .DRT_VERSION   (16'h0002),
    .DRT_ID        (16'hC594),
    .DEV_IDS       ({32'h2, 32'h1}),
    .DEV_FLAGS_INIT({32'h22, 32'h11}),
    .DEV_OFFSETS   ({32'h2000, 32'h1000}),
    .DEV_SIZES     ({32'h200, 32'h100}),
    .WAIT_STATES   (WS),
    .FLAGS_WRITABLE(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat_i),
    .wbs_ack_o(ack),
    .wbs_err_o(err),
    .wbs_dat_o(dat_o),
    .wbs_int_o(int_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_flags[i] = m_init[i];
    m_pending = 1'b0;
  endtask

  // Expected response of one completed access, updating the model state.
  task automatic model_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                              output logic e_ack, output logic e_err, output logic [31:0] e_dat);
    int dev;
    int wd;
    e_ack = 1'b0; e_err = 1'b1; e_dat = 32'h0;
    if (a < 32'(4 + 4 * N)) begin
      if (a < 32'd4) begin
        if (!w) begin
          e_ack = 1'b1; e_err = 1'b0;
          if (a == 32'd0) e_dat = 32'h0002C594;
          else if (a == 32'd1) e_dat = 32'(N);
          else if (a == 32'd2) begin e_dat = {31'b0, m_pending}; m_pending = 1'b0; end
          else e_dat = 32'h0;
        end
      end else begin
        dev = int'(a - 32'd4) / 4;
        wd  = int'(a - 32'd4) % 4;
        if (w) begin
          if (wd == 1) begin
            e_ack = 1'b1; e_err = 1'b0;
            if (d != m_flags[dev]) begin m_flags[dev] = d; m_pending = 1'b1; end
          end
        end else begin
          e_ack = 1'b1; e_err = 1'b0;
          if (wd == 0) e_dat = m_ids[dev];
          else if (wd == 1) e_dat = m_flags[dev];
          else if (wd == 2) e_dat = m_offs[dev];
          else e_dat = m_sizes[dev];
        end
      end
    end
  endtask

  // Drive one request and watch a bounded window of cycles. Strobe is held
  // for 'hold' cycles after the first response is seen.
  task automatic bus_access(input logic [31:0] a, input logic w, input logic [31:0] d, input int hold,
                            output logic r_ack, output logic r_err, output logic [31:0] r_dat,
                            output int latency, output int nresp, output logic bad);
    int   left;
    logic active;
    r_ack = 1'b0; r_err = 1'b0; r_dat = 32'h0;
    latency = -1; nresp = 0; bad = 1'b0; left = -1; active = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
    for (int k = 0; k < 16 + hold; k++) begin
      @(posedge clk); #1;
      if (ack && err) bad = 1'b1;
      if (!ack && !err && (dat_o !== 32'h0)) bad = 1'b1;
      if (ack || err) begin
        nresp++;
        if (latency < 0) begin
          latency = k + 1;
          r_ack = ack; r_err = err; r_dat = dat_o; left = hold;
        end
      end
      if (active && left == 0) begin
        cyc = 1'b0; stb = 1'b0; we = 1'b0; active = 1'b0;
      end else if (left > 0) begin
        left--;
      end
    end
    if (active) begin cyc = 1'b0; stb = 1'b0; we = 1'b0; end
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus_reset(input int cycles);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus_reset(3);
    model_reset();
    n_cmp++; if (ack !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_ack: got %b expected 0", ack); end
    n_cmp++; if (err !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    n_cmp++; if (dat_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_dat: got %h expected 0", dat_o); end
    n_cmp++; if (int_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_int: got %b expected 0", int_o); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Fixed list of accesses: header, map, invalid addresses, flag writes,
  // illegal writes and a same-value rewrite.
  task automatic test_directed();
    logic [31:0] t_adr [15] = '{32'd0, 32'd1, 32'd3, 32'd8, 32'd12, 32'h8000_0004, 32'd5,
                                32'd5, 32'd2, 32'd2, 32'd4, 32'd4, 32'd3, 32'd5, 32'd11};
    logic        t_we  [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] t_dat [15] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hA5,
                                32'h0, 32'h0, 32'h0, 32'hDEAD, 32'h0, 32'h1, 32'hA5, 32'h0};
    logic e_ack, e_err, g_ack, g_err, bad;
    logic [31:0] e_dat, g_dat;
    int lat, nr;
    for (int i = 0; i < 15; i++) begin
      model_access(t_adr[i], t_we[i], t_dat[i], e_ack, e_err, e_dat);
      bus_access(t_adr[i], t_we[i], t_dat[i], 0, g_ack, g_err, g_dat, lat, nr, bad);
      n_cmp++;
      if (g_ack !== e_ack || g_err !== e_err || g_dat !== e_dat) begin
        n_fail++;
        $display("[TB] FAIL directed_resp[%0d] adr=%h we=%b: got ack=%b err=%b dat=%h expected ack=%b err=%b dat=%h",
                 i, t_adr[i], t_we[i], g_ack, g_err, g_dat, e_ack, e_err, e_dat);
      end
      n_cmp++;
      if (lat != WS + 1 || nr != 1 || bad) begin
        n_fail++;
        $display("[TB] FAIL directed_timing[%0d]: got latency=%0d responses=%0d bad=%b expected latency=%0d responses=1 bad=0",
                 i, lat, nr, bad, WS + 1);
      end
      n_cmp++;
      if (int_o !== m_pending) begin
        n_fail++;
        $display("[TB] FAIL directed_int[%0d]: got %b expected %b", i, int_o, m_pending);
      end
    end
  endtask

  task automatic test_back_to_back_hold();
    logic e_ack, e_err, g_ack, g_err, bad;
    logic [31:0] e_dat, g_dat;
    int lat, nr;
    model_access(32'd10, 1'b0, 32'h0, e_ack, e_err, e_dat);
    bus_access(32'd10, 1'b0, 32'h0, 10, g_ack, g_err, g_dat, lat, nr, bad);
    n_cmp++;
    if (nr != 1 || g_ack !== e_ack || g_dat !== e_dat || bad) begin
      n_fail++;
      $display("[TB] FAIL hold_single_ack: got responses=%0d ack=%b dat=%h bad=%b expected responses=1 ack=%b dat=%h",
               nr, g_ack, g_dat, bad, e_ack, e_dat);
    end
  endtask

  task automatic test_abort();
    int seen;
    logic e_ack, e_err, g_ack, g_err, bad;
    logic [31:0] e_dat, g_dat;
    int lat, nr;
    seen = 0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd9; dat_i = 32'h77;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ack || err) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_fail++; $display("[TB] FAIL abort_no_resp: got %0d responses expected 0", seen); end
    model_access(32'd9, 1'b0, 32'h0, e_ack, e_err, e_dat);
    bus_access(32'd9, 1'b0, 32'h0, 0, g_ack, g_err, g_dat, lat, nr, bad);
    n_cmp++;
    if (g_dat !== e_dat || g_ack !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL abort_flags_kept: got ack=%b dat=%h expected ack=1 dat=%h", g_ack, g_dat, e_dat);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    logic e_ack, e_err, g_ack, g_err, bad;
    logic [31:0] e_dat, g_dat;
    int lat, nr;
    seen = 0;
    model_access(32'd9, 1'b1, 32'h5A, e_ack, e_err, e_dat);
    bus_access(32'd9, 1'b1, 32'h5A, 0, g_ack, g_err, g_dat, lat, nr, bad);
    n_cmp++;
    if (int_o !== 1'b1) begin n_fail++; $display("[TB] FAIL pre_reset_int: got %b expected 1", int_o); end
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'd2;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    model_reset();
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ack || err) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_fail++; $display("[TB] FAIL reset_mid_no_resp: got %0d responses expected 0", seen); end
    n_cmp++;
    if (int_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mid_int: got %b expected 0", int_o); end
    for (int i = 0; i < N; i++) begin
      model_access(32'(5 + 4 * i), 1'b0, 32'h0, e_ack, e_err, e_dat);
      bus_access(32'(5 + 4 * i), 1'b0, 32'h0, 0, g_ack, g_err, g_dat, lat, nr, bad);
      n_cmp++;
      if (g_dat !== e_dat) begin
        n_fail++;
        $display("[TB] FAIL reset_mid_flags[%0d]: got %h expected %h", i, g_dat, e_dat);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic w;
    logic e_ack, e_err, g_ack, g_err, bad;
    logic [31:0] e_dat, g_dat;
    int lat, nr;
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 13));
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0001_0000;
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if (w && a >= 32'd4 && a < 32'd12 && a[1:0] == 2'd1 && $urandom_range(0, 1) == 1)
        d = m_flags[int'(a - 32'd4) / 4];
      model_access(a, w, d, e_ack, e_err, e_dat);
      bus_access(a, w, d, 0, g_ack, g_err, g_dat, lat, nr, bad);
      n_cmp++;
      if (g_ack !== e_ack || g_err !== e_err || g_dat !== e_dat) begin
        n_fail++;
        $display("[TB] FAIL random_resp[%0d] adr=%h we=%b: got ack=%b err=%b dat=%h expected ack=%b err=%b dat=%h",
                 i, a, w, g_ack, g_err, g_dat, e_ack, e_err, e_dat);
      end
      n_cmp++;
      if (lat != WS + 1 || nr != 1 || bad || int_o !== m_pending) begin
        n_fail++;
        $display("[TB] FAIL random_timing[%0d]: got latency=%0d responses=%0d bad=%b int=%b expected latency=%0d responses=1 bad=0 int=%b",
                 i, lat, nr, bad, int_o, WS + 1, m_pending);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back_hold();
    test_abort();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
